// File: rtl/iram_pkg.sv
// Shared constants for the multi-port instruction memory and its fetch clients.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iram_pkg;

  // Load FSM encoding
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Default geometry shared with the PC/fetch stages
  localparam int INS_W_DEF  = 21;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH_DEF  = 52;

  // Instruction returned for reads past the loaded program
  localparam logic [INS_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/iram_rd_port.sv
// One registered fetch port: range check against the loaded length, data/valid/oob registers.
// Latency: one cycle from en_i to vld_o/data_o.
// Backpressure: none; data_o holds its last value whenever en_i is low.
module iram_rd_port
  import iram_pkg::*;
#(
  parameter int INS_W  = INS_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W:0]   prog_len_i,
  input  logic [INS_W-1:0]  word_i,
  output logic [INS_W-1:0]  data_o,
  output logic              vld_o,
  output logic              oob_o
);

  logic             oob_d;
  logic [INS_W-1:0] data_q;
  logic             vld_q;
  logic             oob_q;

  // Unsigned compare; prog_len is one bit wider so a full memory is representable
  assign oob_d = ({1'b0, addr_i} >= prog_len_i);

  // Capture the fetched word (or NOP past the program end) only on a request
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      oob_q  <= 1'b0;
    end else if (en_i) begin
      data_q <= oob_d ? INS_W'(NOP) : word_i;
      vld_q  <= 1'b1;
      oob_q  <= oob_d;
    end else begin
      vld_q  <= 1'b0;
      oob_q  <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign oob_o  = oob_q;

endmodule

// File: rtl/iram_mp.sv
// Multi-port instruction memory with a run-time program-load channel and loaded-length tracking.
// Latency: one cycle per fetch port; a load word is written the cycle it is accepted.
// Backpressure: load_ready only in LOAD; fetch ports answer only while mem_ready is high.
module iram_mp
  import iram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int INS_W     = INS_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_valid,
  input  logic [INS_W-1:0]            load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  output logic                        mem_ready,
  output logic [ADDR_W:0]             prog_len,
  input  logic [NUM_PORTS-1:0]        rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS*INS_W-1:0]  rd_data,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [NUM_PORTS-1:0]        rd_oob
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [INS_W-1:0]  ram_q [DEPTH];
  logic              wr_fire;

  // A word is taken only in LOAD and never in a cycle that restarts or resets the load
  assign wr_fire = (state_q == ST_LOAD) && load_valid && !load_start && !rst;

  // Load FSM: rst > load_start > accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
    end else if (load_start) begin
      state_q    <= ST_LOAD;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
    end else if (wr_fire) begin
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (load_last || (wr_ptr_q == LAST_PTR)) begin
        prog_len_q <= {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
        state_q    <= ST_RUN;
      end
    end
  end

  // Program storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      ram_q[wr_ptr_q] <= load_data;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign mem_ready  = (state_q == ST_RUN);
  assign prog_len   = prog_len_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [INS_W-1:0]  word;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
    // Addresses beyond the array are always past prog_len; keep the index in range
    assign word = ({1'b0, addr} < DEPTH_LEN) ? ram_q[addr] : INS_W'(NOP);

    iram_rd_port #(
      .INS_W  (INS_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .en_i       (rd_en[g] & mem_ready),
      .addr_i     (addr),
      .prog_len_i (prog_len_q),
      .word_i     (word),
      .data_o     (rd_data[g*INS_W +: INS_W]),
      .vld_o      (rd_valid[g]),
      .oob_o      (rd_oob[g])
    );
  end

endmodule

// File: tb/tb_iram_mp.sv
// Directed bench for iram_mp: reset, loads, auto-completion at DEPTH, restart, reset mid-load, reads.
module tb_iram_mp;
  localparam int NP = 4;
  localparam int IW = 21;
  localparam int AW = 6;
  localparam int DP = 52;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_start, load_valid, load_last;
  logic [IW-1:0]  load_data;
  logic           load_ready, mem_ready;
  logic [AW:0]    prog_len;
  logic [NP-1:0]  rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*IW-1:0] rd_data;
  logic [NP-1:0]  rd_valid, rd_oob;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NP-1:0]    en;
    logic [NP*AW-1:0] addr;
    logic [NP*IW-1:0] data;
    logic [NP-1:0]    vld;
    logic [NP-1:0]    oob;
  } vec_t;

  vec_t vecs [6];

  iram_mp #(.NUM_PORTS(NP), .INS_W(IW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .mem_ready(mem_ready),
    .prog_len(prog_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  function automatic logic [NP*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NP*IW-1:0] pd(input int d0, input int d1, input int d2, input int d3);
    return {IW'(d3), IW'(d2), IW'(d1), IW'(d0)};
  endfunction

  task automatic rd(input logic [NP-1:0] en, input logic [NP*AW-1:0] a);
    rd_en   = en;
    rd_addr = a;
    tick();
    rd_en   = '0;
  endtask

  initial begin
    // Reads against the 3-word program 0x06000, 0x06400, 0x07000 (prog_len=3)
    vecs[0] = '{4'hf, pa(0, 1, 2, 3),  pd('h06000, 'h06400, 'h07000, 0),       4'hf, 4'h8};
    vecs[1] = '{4'h5, pa(2, 1, 0, 1),  pd('h07000, 'h06400, 'h06000, 0),       4'h5, 4'h0};
    vecs[2] = '{4'hf, pa(1, 1, 1, 1),  pd('h06400, 'h06400, 'h06400, 'h06400), 4'hf, 4'h0};
    vecs[3] = '{4'h0, pa(0, 2, 0, 2),  pd('h06400, 'h06400, 'h06400, 'h06400), 4'h0, 4'h0};
    vecs[4] = '{4'ha, pa(0, 63, 0, 3), pd('h06400, 0, 'h06400, 0),             4'ha, 4'ha};
    vecs[5] = '{4'h1, pa(2, 0, 0, 0),  pd('h07000, 0, 'h06400, 0),             4'h1, 4'h0};

    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; rd_en = '0; rd_addr = '0;

    // 1: reset state and reads before any load
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_rd_data", rd_data, 0);
    rd(4'hf, pa(0, 0, 0, 0));
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_rd_oob", rd_oob, 0);

    // 2: three-word load terminated by load_last
    start_load();
    chk("load_ready_in_load", load_ready, 1);
    push(IW'('h06000), 1'b0);
    push(IW'('h06400), 1'b0);
    chk("mem_ready_mid_load", mem_ready, 0);
    push(IW'('h07000), 1'b1);
    chk("mem_ready_after_last", mem_ready, 1);
    chk("load_ready_after_last", load_ready, 0);
    chk("prog_len_3", prog_len, 3);

    // 3: table of read patterns
    for (int i = 0; i < 6; i++) begin
      rd(vecs[i].en, vecs[i].addr);
      chk($sformatf("vec%0d_data", i), rd_data, vecs[i].data);
      chk($sformatf("vec%0d_valid", i), rd_valid, vecs[i].vld);
      chk($sformatf("vec%0d_oob", i), rd_oob, vecs[i].oob);
    end

    // 4: fill to DEPTH without load_last, then a stray word is refused
    start_load();
    chk("reload_mem_ready", mem_ready, 0);
    chk("reload_prog_len", prog_len, 0);
    for (int i = 0; i < DP - 1; i++) push(IW'('h10000 + i), 1'b0);
    chk("full_minus1_still_load", load_ready, 1);
    push(IW'('h10000 + DP - 1), 1'b0);
    chk("full_mem_ready", mem_ready, 1);
    chk("full_prog_len", prog_len, 52);
    push(IW'('h1ffff), 1'b1);
    chk("full_stray_prog_len", prog_len, 52);
    chk("full_stray_load_ready", load_ready, 0);
    rd(4'hf, pa(0, 51, 52, 63));
    chk("full_rd_data", rd_data, pd('h10000, 'h10033, 0, 0));
    chk("full_rd_oob", rd_oob, 4'hc);

    // 5: reset after 10 words, then restart-in-LOAD with a word on the start cycle
    start_load();
    for (int i = 0; i < 10; i++) push(IW'('h20000 + i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_prog_len", prog_len, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    chk("midrst_load_ready", load_ready, 0);
    start_load();
    push(IW'('h0aaaa), 1'b0);
    load_start = 1'b1;
    push(IW'('h3ffff), 1'b1);
    load_start = 1'b0;
    chk("restart_still_load", load_ready, 1);
    chk("restart_mem_ready", mem_ready, 0);
    push(IW'('h0bbbb), 1'b0);
    push(IW'('h05555), 1'b1);
    chk("restart_prog_len", prog_len, 2);
    rd(4'hf, pa(5, 1, 0, 2));
    chk("restart_rd_data", rd_data, pd(0, 'h05555, 'h0bbbb, 0));
    chk("restart_rd_oob", rd_oob, 4'h9);

    // 6: load_start in RUN while reading
    rd_en = 4'hf; rd_addr = pa(0, 1, 0, 1); load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("run_restart_valid", rd_valid, 4'hf);
    chk("run_restart_data", rd_data, pd('h0bbbb, 'h05555, 'h0bbbb, 'h05555));
    chk("run_restart_mem_ready", mem_ready, 0);
    tick();
    chk("during_load_valid", rd_valid, 0);
    chk("during_load_data_hold", rd_data, pd('h0bbbb, 'h05555, 'h0bbbb, 'h05555));
    push(IW'('h01234), 1'b1);
    chk("final_load_valid", rd_valid, 0);
    chk("final_prog_len", prog_len, 1);
    rd(4'hf, pa(0, 0, 1, 0));
    chk("final_rd_data", rd_data, pd('h01234, 'h01234, 0, 'h01234));
    chk("final_rd_valid", rd_valid, 4'hf);
    chk("final_rd_oob", rd_oob, 4'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iram_mp.md
Name: iram_mp

Overview:
- Parametrised multi-port instruction memory, successor to the fixed 4-port, 21-bit, 52-word instruction store.
- Serves NUM_PORTS core fetch ports with registered one-cycle reads.
- Adds a run-time program-load channel with a valid/ready handshake, a loaded-length register and out-of-range detection, replacing compile-time-only contents.
- Sits between the program loader and the per-core PC/fetch stages.

Parameters:
NUM_PORTS, 4, number of independent read (fetch) ports
INS_W, 21, instruction word width in bits
ADDR_W, 6, PC/address width per port
DEPTH, 52, number of instruction words; must satisfy DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
load_start  in  1  begin a new program load; resets write pointer
load_valid  in  1  load_data/load_last valid this cycle
load_data  in  INS_W  instruction word to write
load_last  in  1  marks final word of the program
load_ready  out  1  block accepts a load word this cycle
mem_ready  out  1  program loaded; fetch ports active
prog_len  out  ADDR_W+1  number of valid words loaded
rd_en  in  NUM_PORTS  per-port read request
rd_addr  in  NUM_PORTS*ADDR_W  packed per-port PC; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_PORTS*INS_W  packed per-port instruction; port i at [i*INS_W +: INS_W]
rd_valid  out  NUM_PORTS  rd_data[i] valid this cycle
rd_oob  out  NUM_PORTS  port i read address >= prog_len

Behaviour:
Reset values:
- state=EMPTY; wr_ptr=0; prog_len=0.
- load_ready=0, mem_ready=0.
- rd_data, rd_valid and rd_oob all 0.
- RAM contents are not cleared.

FSM states EMPTY, LOAD, RUN:
- EMPTY: load_ready=0, mem_ready=0; load_start -> LOAD with wr_ptr=0.
- LOAD: load_ready=1. On load_valid&load_ready:
  - ram[wr_ptr]<=load_data; wr_ptr++.
  - If load_last=1 or wr_ptr==DEPTH-1: prog_len<=wr_ptr+1 and go to RUN next cycle.
- LOAD boundary: load_start in LOAD restarts with wr_ptr=0; the load_start cycle writes nothing even if load_valid is high.
- RUN: mem_ready=1, load_ready=0; load_start -> LOAD, prog_len<=0, mem_ready drops the next cycle.

Precedence and reset:
- Priority is rst > load_start > load_valid.
- rst mid-LOAD -> EMPTY; partial program discarded (prog_len=0).

Reads:
- Port i with rd_en[i]=1 in cycle N while state==RUN: rd_valid[i]=1 in N+1.
- rd_data[i] in N+1 is ram[rd_addr[i]] if addr<prog_len; otherwise rd_data[i]=0 (NOP) and rd_oob[i]=1.
- rd_en[i] in EMPTY/LOAD: rd_valid[i]=0, rd_oob[i]=0, rd_data[i] holds.
- rd_en[i]=0: rd_valid[i]=0, rd_oob[i]=0, rd_data[i] holds its last value.
- All ports are independent. Any ports may read the same address in the same cycle; all get identical data.
- Reads and writes never overlap because reads are gated to RUN only; no bypass is required.
- prog_len is ADDR_W+1 bits so DEPTH==2**ADDR_W is representable; the comparison is unsigned.

Decomposition:
- Shared package iram_pkg holds:
  - state encoding constants (EMPTY=2'd0, LOAD=2'd1, RUN=2'd2);
  - NOP encoding constant (all zeros);
  - default INS_W/ADDR_W/DEPTH constants shared with the fetch stages.
- Natural sub-module: iram_rd_port, one registered read port (enable, oob compare, data/valid registers), instantiated NUM_PORTS times via generate.
- Load FSM and storage array stay in the top module.

Test Plan:
1. Reset, then rd_en=4'b1111 with addr 0 -> rd_valid=0 on all ports; mem_ready=0, prog_len=0.
2. Load 3 words 0x06000, 0x06400, 0x07000 with load_last on the third -> load_ready high during load, mem_ready=1 one cycle after the third word, prog_len=3.
3. In RUN, ports 0..3 read addr 0,1,2,3 in the same cycle -> next cycle rd_data = 0x06000, 0x06400, 0x07000, 0; rd_valid=4'b1111; rd_oob=4'b1000.
4. Load DEPTH=52 words with load_last never asserted -> auto-transition to RUN after word 51, prog_len=52; a load_valid in the following cycle is ignored (load_ready=0).
5. Assert rst after 10 load words, then load_start and 2 words with load_last -> prog_len=2; a read at addr 5 gives rd_oob=1, rd_data=0.
6. load_start in RUN while rd_en=1 -> rd_valid is still 1 for that cycle's request; mem_ready=0 the next cycle; later rd_en gives rd_valid=0 until the reload completes.
